// File: rtl/elastic_pkg.sv
// Shared helpers for the elastic FIFO family: lane-index width and handshake fire.
package elastic_pkg;

  // Width of a counter that indexes n lanes (never narrower than one bit).
  function automatic int unsigned lane_idx_w(input int unsigned n);
    if (n > 32'd1) begin
      return $clog2(n);
    end else begin
      return 32'd1;
    end
  endfunction

  // A transfer happens when both sides of a valid/ready pair agree.
  function automatic logic hs_fire(input logic valid, input logic ready);
    return valid & ready;
  endfunction

endpackage

// File: rtl/elastic_out_reg.sv
// Registered output word with valid flag; holds the word until the consumer takes it.
// A load in the same cycle as a consume replaces the word and keeps valid asserted.
module elastic_out_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic [WIDTH-1:0] dout,
  output logic             valid
);

  // Load a new word, drop valid once the consumer takes it, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout  <= {WIDTH{1'b0}};
      valid <= 1'b0;
    end else if (load) begin
      dout  <= din;
      valid <= 1'b1;
    end else if (valid & ready) begin
      valid <= 1'b0;
    end else begin
      valid <= valid;
    end
  end

endmodule

// File: rtl/elastic_upsizer.sv
// Packs RATIO narrow beats into one wide word (first beat in the LSB lane) and
// presents it through a registered valid/ready output stage.
// Optional feature macro: ELASTIC_UPSIZER_LAST_EN adds last_in (early word
// termination, upper lanes zeroed) and beats_out (beats carried by the word).
module elastic_upsizer
  import elastic_pkg::*;
#(
  parameter  int DATA_IN_SIZE  = 8,
  parameter  int RATIO         = 4,
  localparam int DATA_OUT_SIZE = DATA_IN_SIZE * RATIO
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_IN_SIZE-1:0]  data_in,
  input  logic                     valid_in,
  output logic                     ready_in,
  output logic [DATA_OUT_SIZE-1:0] data_out,
  output logic                     valid_out,
  input  logic                     ready_out
`ifdef ELASTIC_UPSIZER_LAST_EN
  ,
  input  logic                     last_in,
  output logic [$clog2(RATIO):0]   beats_out
`endif
);

  localparam int CNT_W   = lane_idx_w(RATIO);
  localparam int BEATS_W = $clog2(RATIO) + 1;
  localparam int ACC_W   = DATA_IN_SIZE * (RATIO - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RATIO - 1);

`ifdef ELASTIC_UPSIZER_LAST_EN
  localparam int PAY_W = DATA_OUT_SIZE + BEATS_W;
`else
  localparam int PAY_W = DATA_OUT_SIZE;
`endif

  logic [CNT_W-1:0]         cnt_r;
  logic [ACC_W-1:0]         acc_r;
  logic [DATA_OUT_SIZE-1:0] acc_ext_s;
  logic [DATA_OUT_SIZE-1:0] word_s;
  logic [PAY_W-1:0]         payload_s;
  logic [PAY_W-1:0]         payload_q_s;
  logic                     final_beat_s;
  logic                     ready_s;
  logic                     fire_s;

  // A beat closes the word when it fills the top lane (or is flagged last).
`ifdef ELASTIC_UPSIZER_LAST_EN
  assign final_beat_s = (cnt_r == CNT_MAX) | last_in;
`else
  assign final_beat_s = (cnt_r == CNT_MAX);
`endif

  // Only a closing beat needs room in the output register; reset forces ready
  // so beats offered during reset are taken and then ignored.
  assign ready_s  = rst | ~final_beat_s | ~valid_out | ready_out;
  assign ready_in = ready_s;
  assign fire_s   = hs_fire(valid_in, ready_s) & ~rst;

  // Assemble the outgoing word: stored lanes below cnt, the live beat at cnt, zeros above.
  always_comb begin
    acc_ext_s = {{DATA_IN_SIZE{1'b0}}, acc_r};
    word_s    = {DATA_OUT_SIZE{1'b0}};
    for (int j = 0; j < RATIO; j++) begin
      if (j < int'(cnt_r)) begin
        word_s[j*DATA_IN_SIZE +: DATA_IN_SIZE] = acc_ext_s[j*DATA_IN_SIZE +: DATA_IN_SIZE];
      end else if (j == int'(cnt_r)) begin
        word_s[j*DATA_IN_SIZE +: DATA_IN_SIZE] = data_in;
      end else begin
        word_s[j*DATA_IN_SIZE +: DATA_IN_SIZE] = {DATA_IN_SIZE{1'b0}};
      end
    end
  end

`ifdef ELASTIC_UPSIZER_LAST_EN
  assign payload_s = {BEATS_W'(cnt_r) + BEATS_W'(1), word_s};
  assign beats_out = payload_q_s[PAY_W-1 -: BEATS_W];
`else
  assign payload_s = word_s;
`endif
  assign data_out = payload_q_s[DATA_OUT_SIZE-1:0];

  // Beat counter: advance on each non-final beat, wrap to lane 0 on the final one.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (fire_s) begin
      if (final_beat_s) begin
        cnt_r <= {CNT_W{1'b0}};
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Accumulator lanes: capture a non-final beat into its lane; contents need no reset.
  always_ff @(posedge clk) begin
    if (fire_s && !final_beat_s) begin
      acc_r[int'(cnt_r)*DATA_IN_SIZE +: DATA_IN_SIZE] <= data_in;
    end else begin
      acc_r <= acc_r;
    end
  end

  elastic_out_reg #(
    .WIDTH (PAY_W)
  ) u_out_reg (
    .clk   (clk),
    .rst   (rst),
    .load  (fire_s & final_beat_s),
    .din   (payload_s),
    .ready (ready_out),
    .dout  (payload_q_s),
    .valid (valid_out)
  );

endmodule

// File: tb/tb_elastic_upsizer.sv
// Directed and randomised checks for elastic_upsizer (DATA_IN_SIZE=8, RATIO=4).
module tb_elastic_upsizer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  data_in;
  logic        valid_in;
  logic        ready_in;
  logic [31:0] data_out;
  logic        valid_out;
  logic        ready_out;
`ifdef ELASTIC_UPSIZER_LAST_EN
  logic        last_in;
  logic [2:0]  beats_out;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  elastic_upsizer #(
    .DATA_IN_SIZE (8),
    .RATIO        (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .ready_out (ready_out)
`ifdef ELASTIC_UPSIZER_LAST_EN
    ,
    .last_in   (last_in),
    .beats_out (beats_out)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] d);
    valid_in = 1'b1;
    data_in  = d;
    tick();
    valid_in = 1'b0;
  endtask

  logic [31:0] q[$];
  logic [31:0] exp_word;
  logic [31:0] held_word;
  logic        held;
  int          lane;
  int          sent;
  localparam int NB = 10000;

  initial begin
    rst = 1'b1; valid_in = 1'b0; ready_out = 1'b1; data_in = 8'h00;
`ifdef ELASTIC_UPSIZER_LAST_EN
    last_in = 1'b0;
`endif
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_valid", 64'(valid_out), 64'd0);
    check("rst_data",  64'(data_out),  64'd0);
    check("rst_ready", 64'(ready_in),  64'd1);

    // four beats back to back
    beat(8'h11); beat(8'h22); beat(8'h33);
    check("t1_not_yet", 64'(valid_out), 64'd0);
    beat(8'h44);
    check("t1_valid", 64'(valid_out), 64'd1);
    check("t1_data",  64'(data_out),  64'h44332211);
    tick();
    check("t1_consumed", 64'(valid_out), 64'd0);

    // continuous stream of eight beats
    for (int i = 0; i < 8; i++) begin
      valid_in = 1'b1;
      data_in  = 8'(i + 1);
      #1;
      check("t2_ready", 64'(ready_in), 64'd1);
      tick();
      if (i == 3) begin
        check("t2_w1", {31'd0, valid_out, data_out}, {31'd0, 1'b1, 32'h04030201});
      end
      if (i == 4) begin
        check("t2_gap", 64'(valid_out), 64'd0);
      end
      if (i == 7) begin
        check("t2_w2", {31'd0, valid_out, data_out}, {31'd0, 1'b1, 32'h08070605});
      end
    end
    valid_in = 1'b0;
    tick();

    // back-pressure with a full accumulator
    ready_out = 1'b0;
    beat(8'hB0); beat(8'hB1); beat(8'hB2); beat(8'hB3);
    check("t3_w1", {31'd0, valid_out, data_out}, {31'd0, 1'b1, 32'hB3B2B1B0});
    beat(8'hC0); beat(8'hC1); beat(8'hC2);
    valid_in = 1'b1; data_in = 8'hC3;
    #1;
    check("t3_stall_ready", 64'(ready_in), 64'd0);
    tick();
    check("t3_hold", {31'd0, valid_out, data_out}, {31'd0, 1'b1, 32'hB3B2B1B0});
    ready_out = 1'b1;
    #1;
    check("t3_release_ready", 64'(ready_in), 64'd1);
    tick();
    check("t3_w2", {31'd0, valid_out, data_out}, {31'd0, 1'b1, 32'hC3C2C1C0});
    valid_in = 1'b0;
    tick();
    check("t3_drained", 64'(valid_out), 64'd0);

    // reset in the middle of a word
    beat(8'hD0); beat(8'hD1);
    rst = 1'b1; valid_in = 1'b1; data_in = 8'hEE;
    #1;
    check("t4_rst_ready", 64'(ready_in), 64'd1);
    tick();
    rst = 1'b0; valid_in = 1'b0;
    check("t4_rst_out", {31'd0, valid_out, data_out}, 64'd0);
    beat(8'hA0); beat(8'hA1); beat(8'hA2); beat(8'hA3);
    check("t4_word", {31'd0, valid_out, data_out}, {31'd0, 1'b1, 32'hA3A2A1A0});
    tick();

`ifdef ELASTIC_UPSIZER_LAST_EN
    // early termination with last_in
    beat(8'h01);
    last_in = 1'b1;
    beat(8'h02);
    last_in = 1'b0;
    check("t5_data",  64'(data_out),  64'h00000201);
    check("t5_beats", 64'(beats_out), 64'd2);
    beat(8'h55); beat(8'h56); beat(8'h57); beat(8'h58);
    check("t5_full",  64'(data_out),  64'h58575655);
    check("t5_fbeats", 64'(beats_out), 64'd4);
    tick();
    last_in = 1'b0;
`endif

    // random valid/ready traffic against a packing scoreboard
    held = 1'b0; lane = 0; sent = 0; exp_word = 32'd0;
    for (int cyc = 0; cyc < 80000 && sent < NB; cyc++) begin
      valid_in  = ($urandom_range(0, 3) != 0);
      data_in   = 8'($urandom);
      ready_out = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (held) begin
        check("rnd_hold", {31'd0, valid_out, data_out}, {31'd0, 1'b1, held_word});
      end
      held      = valid_out & ~ready_out;
      held_word = data_out;
      if (valid_out && ready_out) begin
        if (q.size() == 0) begin
          check("rnd_dup", 64'd1, 64'd0);
        end else begin
          check("rnd_word", 64'(data_out), 64'(q.pop_front()));
        end
      end
      if (valid_in && ready_in) begin
        exp_word[lane*8 +: 8] = data_in;
        sent++;
        if (lane == 3) begin
          q.push_back(exp_word);
          lane = 0;
        end else begin
          lane++;
        end
      end
      tick();
    end
    check("rnd_sent", 64'(sent), 64'(NB));
    valid_in = 1'b0; ready_out = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (valid_out && ready_out) begin
        if (q.size() == 0) begin
          check("rnd_dup", 64'd1, 64'd0);
        end else begin
          check("rnd_word", 64'(data_out), 64'(q.pop_front()));
        end
      end
      tick();
    end
    check("rnd_empty", 64'(q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/elastic_upsizer.md
ELASTIC_UPSIZER -- requirements
Module: elastic_upsizer

Interface
REQ-001 SHALL have parameter DATA_IN_SIZE, default 8, narrow input beat width in bits.
REQ-002 SHALL have parameter RATIO, default 4, number of input beats per output word; legal range RATIO >= 2.
REQ-003 SHALL have derived localparam DATA_OUT_SIZE = DATA_IN_SIZE*RATIO, which is the width of the downstream elastic FIFO input.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port data_in, input, DATA_IN_SIZE, the narrow beat.
REQ-007 SHALL have port valid_in, input, 1, upstream beat valid.
REQ-008 SHALL have port ready_in, output, 1, beat accepted when valid_in & ready_in.
REQ-009 SHALL have port data_out, output, DATA_OUT_SIZE, the packed word.
REQ-010 SHALL have port valid_out, output, 1, packed word valid.
REQ-011 SHALL have port ready_out, input, 1, downstream (FIFO ready_in) accepts the word.

Function
REQ-012 SHALL keep a beat counter cnt (0..RATIO-1) and RATIO-1 accumulator lanes, plus one registered output word with valid flag.
REQ-013 SHALL place beat k of a word in data_out[k*DATA_IN_SIZE +: DATA_IN_SIZE]; the first beat goes in the LSB lane.
REQ-014 On an accepted beat with cnt < RATIO-1, SHALL store the beat in lane cnt and increment cnt.
REQ-015 On an accepted beat with cnt == RATIO-1, SHALL load the output register with the accumulator lanes plus data_in in the top lane, set valid_out, and return cnt to 0.
REQ-016 ready_in SHALL equal (cnt != RATIO-1) | ~valid_out | ready_out, combinationally.
REQ-017 Latency: the word SHALL appear on data_out/valid_out exactly one cycle after the handshake of its final beat.
REQ-018 valid_out SHALL clear on a cycle where ready_out & valid_out holds, unless a final beat is accepted in that same cycle, in which case the new word is loaded and valid_out stays 1.
REQ-019 data_out and valid_out SHALL hold stable while valid_out & ~ready_out.
REQ-020 Throughput: SHALL sustain one beat per cycle with ready_out tied high; no bubble at word boundaries.
REQ-021 Accumulator lanes not written in a cycle SHALL keep their value; valid_in without ready_in SHALL have no effect.

Reset
REQ-022 rst SHALL set cnt=0, valid_out=0, and data_out to all zeros; accumulator contents are don't-care.
REQ-023 rst during a partial word SHALL discard the collected beats; the next accepted beat goes to lane 0.
REQ-024 While rst is high, ready_in SHALL evaluate with cnt=0, i.e. be 1; beats offered during reset are dropped.

Configuration
REQ-025 Macro ELASTIC_UPSIZER_LAST_EN defined SHALL add input last_in (1) and output beats_out ($clog2(RATIO)+1 bits).
REQ-026 With the macro, an accepted beat with last_in=1 SHALL emit the word immediately (treated as a final beat per REQ-015/016 for that beat), zero all lanes above it, set beats_out=cnt+1, and return cnt to 0.
REQ-027 With the macro, full words SHALL report beats_out=RATIO, and reset SHALL clear beats_out to 0.
REQ-028 Without the macro, last_in and beats_out SHALL be absent and every word SHALL carry RATIO beats.

Structure
REQ-029 A shared package elastic_pkg SHALL hold the lane-index width function and the handshake-fire helper, reused by the elastic FIFO family.
REQ-030 The output register with valid/ready hold SHALL be a sub-module elastic_out_reg; the counter and lanes stay in the top level.

Verification
REQ-031 Reset release, DATA_IN_SIZE=8, RATIO=4: beats 0x11, 0x22, 0x33, 0x44 back-to-back with ready_out=1 -> data_out=0x44332211 and valid_out=1 one cycle after 0x44.
REQ-032 Continuous stream of 8 beats with ready_out=1 -> two words on consecutive word slots, ready_in never low.
REQ-033 Word held with ready_out=0 and cnt=3 -> ready_in=0, data_out stable; then raise ready_out together with a final beat -> new word loaded and valid_out stays 1.
REQ-034 rst asserted after 2 beats, then 4 beats 0xA0..0xA3 -> data_out=0xA3A2A1A0.
REQ-035 With LAST_EN: beats 0x01, 0x02 with last_in=1 on 0x02 -> data_out=0x00000201, beats_out=2.
REQ-036 Random valid_in/ready_out over 10k beats -> output word stream equals the scoreboard-packed input stream, with no loss or duplication.
